// File: rtl/logic_gate_array_seq_if.sv
// Operand/result stream of the gate array: a valid/ready input side carrying
// (a,b) and a valid/ready output side carrying the five registered gate results.
interface logic_gate_array_seq_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o_and;
  logic [WIDTH-1:0] o_or;
  logic [WIDTH-1:0] o_nand;
  logic [WIDTH-1:0] o_nor;
  logic [WIDTH-1:0] o_xor;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out_valid, o_and, o_or, o_nand, o_nor, o_xor
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out_valid, o_and, o_or, o_nand, o_nor, o_xor
  );
endinterface

// File: rtl/logic_gate_array_seq.sv
// Registered WIDTH-bit AND/OR/NAND/NOR/XOR array with a valid/ready output stage
// and a built-in exhaustive sweep engine that folds every (a,b) result into a signature.
module logic_gate_array_seq #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  logic_gate_array_seq_if.slave gate,
  input  logic                  sweep_start,
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic [15:0]           signature
);

  localparam int CNT_W  = 2 * WIDTH;
  localparam int WORD_W = 5 * WIDTH;
  localparam int CHUNKS = (WORD_W + 15) / 16;
  localparam int PAD_W  = CHUNKS * 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             sweep_go;
  logic             sweep_last;
  logic             accept;
  logic [15:0]      sweep_fold;

  // {and, or, nand, nor, xor} with AND in the most significant bits.
  function automatic logic [WORD_W-1:0] gate_word(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    return {x & y, x | y, ~(x & y), ~(x | y), x ^ y};
  endfunction

  function automatic logic [15:0] fold16(input logic [WORD_W-1:0] word);
    logic [PAD_W-1:0] padded;
    logic [15:0]      acc;
    padded = PAD_W'(word);
    acc    = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      acc = acc ^ padded[i*16 +: 16];
    end
    return acc;
  endfunction

  // A start request owns the cycle: no operand pair may slip in alongside it.
  assign sweep_go      = (state == IDLE) & sweep_start;
  assign gate.in_ready = (state == IDLE) & ~sweep_start & (~gate.out_valid | gate.out_ready);
  assign accept        = gate.in_valid & gate.in_ready;
  assign sweep_last    = (cnt == {CNT_W{1'b1}});
  assign sweep_fold    = fold16(gate_word(cnt[CNT_W-1:WIDTH], cnt[WIDTH-1:0]));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    sweep_busy = 1'b0;
    sweep_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (sweep_start) state_next = SWEEP;
      end
      SWEEP: begin
        sweep_busy = 1'b1;
        if (sweep_last) state_next = DONE;
      end
      DONE: begin
        sweep_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counter wraps to zero on the terminal pair, so it is already clean for the next sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      signature <= 16'h0000;
    end else if (sweep_go) begin
      cnt       <= '0;
      signature <= 16'h0000;
    end else if (state == SWEEP) begin
      cnt       <= cnt + CNT_W'(1);
      signature <= {signature[14:0], signature[15]} ^ sweep_fold;
    end
  end

  // Manual result stage: loads on accept, holds under backpressure, and is
  // left untouched by the sweep so a pending result can still drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate.out_valid <= 1'b0;
      gate.o_and     <= '0;
      gate.o_or      <= '0;
      gate.o_nand    <= '0;
      gate.o_nor     <= '0;
      gate.o_xor     <= '0;
    end else if (accept) begin
      gate.out_valid <= 1'b1;
      gate.o_and     <= gate.a & gate.b;
      gate.o_or      <= gate.a | gate.b;
      gate.o_nand    <= ~(gate.a & gate.b);
      gate.o_nor     <= ~(gate.a | gate.b);
      gate.o_xor     <= gate.a ^ gate.b;
    end else if (gate.out_ready) begin
      gate.out_valid <= 1'b0;
    end
  end

endmodule
